// File: rtl/la_pkg.sv
// rtl/la_pkg.sv - Shared state and trigger-mode types for the logic-analyzer capture core
package la_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_WAIT,
        ST_POST,
        ST_DONE
    } la_state_t;

    typedef enum logic [1:0] {
        TRIG_LEVEL,
        TRIG_RISE,
        TRIG_FALL,
        TRIG_CHANGE
    } la_trig_mode_t;

endpackage

// File: rtl/la_ring_ram.sv
// rtl/la_ring_ram.sv - Simple dual-port sample RAM, one write port, registered read with 1-cycle latency
module la_ring_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1024,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/la_capture_core.sv
// rtl/la_capture_core.sv - Logic-analyzer capture engine: circular buffer, pre-trigger window, streamed readout
// Define LA_STORAGE_QUALIFIER_EN to add qual_i; only qualified cycles then count as samples.
module la_capture_core
    import la_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int TRIG_W = 8,
    parameter int DEPTH  = 1024,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [TRIG_W-1:0] trig_i,
    input  logic [TRIG_W-1:0] trig_mask_i,
    input  logic [TRIG_W-1:0] trig_value_i,
    input  logic [1:0]        trig_mode_i,
    input  logic [ADDR_W-1:0] pretrig_i,
    input  logic              arm_i,
    input  logic              abort_i,
`ifdef LA_STORAGE_QUALIFIER_EN
    input  logic              qual_i,
`endif
    output logic              armed_o,
    output logic              triggered_o,
    output logic              done_o,
    output logic              rd_valid_o,
    input  logic              rd_ready_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_last_o
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
    localparam logic [ADDR_W:0]   ONE_C    = (ADDR_W + 1)'(1);

    la_state_t         state;
    la_trig_mode_t     mode_r;
    logic [TRIG_W-1:0] mask_r, value_r, prev;
    logic [ADDR_W-1:0] p_r, wp, cnt, ra, beat_cnt;
    logic [ADDR_W:0]   iss_cnt;
    logic              sample, we, hit, issue, pop, pend, skid_v;
    logic [1:0]        occ;
    logic [DATA_W-1:0] ram_q, skid_q;

`ifdef LA_STORAGE_QUALIFIER_EN
    assign sample = qual_i;
`else
    assign sample = 1'b1;
`endif

    assign we          = sample && (state == ST_FILL || state == ST_WAIT || state == ST_POST);
    assign armed_o     = (state == ST_FILL) || (state == ST_WAIT);
    assign triggered_o = (state == ST_POST) || (state == ST_DONE);
    assign done_o      = (state == ST_DONE);
    assign rd_last_o   = rd_valid_o && (beat_cnt == LAST_IDX);
    assign pop         = rd_valid_o && rd_ready_i;

    // Reads in flight plus buffered beats never exceed two, so output and skid registers always have room.
    assign occ   = {1'b0, rd_valid_o} + {1'b0, skid_v} + {1'b0, pend};
    assign issue = (state == ST_DONE) && !iss_cnt[ADDR_W] && ((occ - {1'b0, pop}) < 2'd2);

    always_comb begin
        hit = 1'b0;
        case (mode_r)
            TRIG_LEVEL:  hit = ((trig_i ^ value_r) & mask_r) == '0;
            TRIG_RISE:   hit = |(trig_i & ~prev & mask_r);
            TRIG_FALL:   hit = |(~trig_i & prev & mask_r);
            TRIG_CHANGE: hit = |((trig_i ^ prev) & mask_r);
            default:     hit = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev <= '0;
        end else if (sample) begin
            prev <= trig_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || abort_i) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (arm_i) begin
                    p_r      <= pretrig_i;
                    mask_r   <= trig_mask_i;
                    value_r  <= trig_value_i;
                    mode_r   <= la_trig_mode_t'(trig_mode_i);
                    wp       <= '0;
                    cnt      <= '0;
                    iss_cnt  <= '0;
                    beat_cnt <= '0;
                    state    <= (pretrig_i == '0) ? ST_WAIT : ST_FILL;
                end
                ST_FILL: if (sample) begin
                    wp  <= wp + ONE_A;
                    cnt <= cnt + ONE_A;
                    if (cnt == p_r - ONE_A) state <= ST_WAIT;
                end
                ST_WAIT: if (sample) begin
                    wp <= wp + ONE_A;
                    if (hit) begin
                        ra    <= wp - p_r;
                        cnt   <= '0;
                        state <= (p_r == LAST_IDX) ? ST_DONE : ST_POST;
                    end
                end
                ST_POST: if (sample) begin
                    wp  <= wp + ONE_A;
                    cnt <= cnt + ONE_A;
                    if (cnt == LAST_IDX - ONE_A - p_r) state <= ST_DONE;
                end
                ST_DONE: begin
                    if (issue) begin
                        ra      <= ra + ONE_A;
                        iss_cnt <= iss_cnt + ONE_C;
                    end
                    if (pop) begin
                        beat_cnt <= beat_cnt + ONE_A;
                        if (beat_cnt == LAST_IDX) state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || abort_i) begin
            rd_valid_o <= 1'b0;
            rd_data_o  <= '0;
            skid_v     <= 1'b0;
            skid_q     <= '0;
            pend       <= 1'b0;
        end else begin
            pend <= issue;
            if (!rd_valid_o || pop) begin
                if (skid_v) begin
                    rd_data_o  <= skid_q;
                    rd_valid_o <= 1'b1;
                    skid_v     <= pend;
                    skid_q     <= ram_q;
                end else begin
                    rd_valid_o <= pend;
                    if (pend) rd_data_o <= ram_q;
                end
            end else if (pend) begin
                skid_v <= 1'b1;
                skid_q <= ram_q;
            end
        end
    end

    la_ring_ram #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk  (clk_i),
        .we   (we),
        .waddr(wp),
        .wdata(data_i),
        .re   (issue),
        .raddr(ra),
        .rdata(ram_q)
    );

endmodule

// File: doc/la_capture_core.md
# la_capture_core

Parametrised on-chip logic-analyzer capture engine with a circular sample buffer, programmable pre-trigger depth and selectable trigger modes. It records `DATA_W` probe signals in one capture clock domain. After a capture completes, it streams the stored window out oldest-first over a valid/ready port to the team's debug readout path. It generalises the fixed single-signal, fixed-trigger analyzer instance in camera/SDRAM debug builds into a reusable core.

## Interface
Parameters:
- `DATA_W`, 16: probe data width
- `TRIG_W`, 8: trigger input width
- `DEPTH`, 1024: samples per capture; power of two, ≥ 4
- `ADDR_W` (localparam): `$clog2(DEPTH)`

Ports (one clock `clk_i`; reset `rst_i` is synchronous, active-high):
- `clk_i`  in  1  capture clock
- `rst_i`  in  1  synchronous active-high reset
- `data_i`  in  DATA_W  probe data
- `trig_i`  in  TRIG_W  trigger signals
- `trig_mask_i`  in  TRIG_W  trigger bit enable
- `trig_value_i`  in  TRIG_W  level-mode compare value
- `trig_mode_i`  in  2  0 level, 1 rising, 2 falling, 3 any-change
- `pretrig_i`  in  ADDR_W  pre-trigger sample count P
- `arm_i`  in  1  start capture (one-cycle pulse)
- `abort_i`  in  1  return to IDLE from any state
- `qual_i`  in  1  storage qualifier (only with `LA_STORAGE_QUALIFIER_EN`)
- `armed_o`  out  1  high in FILL/WAIT
- `triggered_o`  out  1  high in POST/DONE
- `done_o`  out  1  high in DONE
- `rd_valid_o`  out  1  readout beat valid
- `rd_ready_i`  in  1  readout accept
- `rd_data_o`  out  DATA_W  readout sample
- `rd_last_o`  out  1  final beat (sample DEPTH-1)

## Operation
- States: IDLE → FILL → WAIT → POST → DONE → IDLE.
- IDLE: `arm_i` latches P, `trig_*_i` and the mode; clears the write pointer wp and counters; enters FILL. `arm_i` is ignored in all other states.
- FILL: stores each sample at wp and increments wp modulo DEPTH. The trigger is ignored. After P samples, enters WAIT. If P=0, goes straight to WAIT.
- WAIT: stores samples continuously; the ring wraps. The first sample with the trigger true is stored at wp. That address is latched as ta, and the state moves to POST.
- POST: stores DEPTH-1-P further samples, then enters DONE. If P=DEPTH-1, enters DONE immediately after the trigger sample.
- Trigger condition, evaluated on the current sample:
  - Level: `((trig_i ^ value) & mask) == 0`.
  - Rising: any masked bit with prev=0 and cur=1.
  - Falling: any masked bit with prev=1 and cur=0.
  - Change: any masked bit differs from prev.
  - mask=0: level fires on the first WAIT sample; edge modes never fire.
- prev register: updated every sample cycle in every state; 0 after reset.
- DONE: reads DEPTH samples from address `ta-P` upward, modulo DEPTH. The readout therefore holds P pre-trigger samples, then the trigger sample at index P, then the post-trigger samples.
- Readout handshake: a beat transfers when `rd_valid_o && rd_ready_i`. `rd_data_o`/`rd_last_o` hold stable while valid is high and ready is low. When the beat with `rd_last_o` is accepted, the core goes to IDLE.
- `abort_i` takes priority over everything except `rst_i`. From any state it goes to IDLE and drops `rd_valid_o`.
- `rst_i` mid-operation: goes to IDLE; RAM contents are not cleared.

## Timing
- All outputs reset to 0.
- `armed_o` rises the cycle after `arm_i`.
- `triggered_o` rises the cycle after the trigger sample.
- `done_o` rises the cycle after the final post-trigger write and falls the cycle after the last beat is accepted.
- `rd_valid_o` first asserts exactly 2 cycles after `done_o` rises: one cycle for the RAM's registered read, one for the output register.
- Once the first beat is valid, readout sustains 1 beat/cycle under continuous `rd_ready_i`; a prefetch/skid register absorbs ready deassertion with no bubble.
- Capture latency: trigger-to-`done_o` = DEPTH-P cycles with no qualification.

## Configuration
- `LA_STORAGE_QUALIFIER_EN` defined: a sample cycle is one with `qual_i`=1. Storage, wp advance, counters, trigger evaluation and prev update occur only on those cycles.
- Undefined: the `qual_i` port is absent and every cycle is a sample cycle.

## Structure
- Package `la_pkg` holds the state enum `la_state_t` and the trigger-mode enum `la_trig_mode_t` (LEVEL, RISE, FALL, CHANGE).
- Sub-module `la_ring_ram`: simple dual-port RAM, DEPTH×DATA_W, one write port and one registered read port with 1-cycle latency. It maps to BSRAM.

## Test plan
All scenarios use DEPTH=16, data_i = free-running cycle counter.
- Level trigger: mask=0x01, value=0x01, P=4, bit0 high at counter 40 → readout 36..51, `rd_last_o` on 51, core in IDLE after.
- Rising, P=0, trig_i bit3 pulse at counter 100 → first beat 100, 16 beats total; `rd_valid_o` exactly 2 cycles after `done_o`.
- Backpressure: random `rd_ready_i` at 50% duty → 16 beats in order, no drops or duplicates, data held stable while stalled.
- Boundaries: P=15 → trigger sample is beat 15 and is the last beat. mask=0 in rising mode → stays in WAIT indefinitely.
- `abort_i` in POST, then `rst_i` during readout beat 5 → IDLE, all outputs 0 next cycle; a fresh arm captures correctly.
- With `LA_STORAGE_QUALIFIER_EN` and `qual_i` high on even counters → readout holds only even values; the trigger is ignored on odd cycles.
